// File: rtl/nand_pkg.sv
// rtl/nand_pkg.sv - shared command codes, FSM/mode enums and ID bytes for the NAND target model
package nand_pkg;

    localparam logic [7:0] CMD_READ     = 8'h00;
    localparam logic [7:0] CMD_READ_CFM = 8'h30;
    localparam logic [7:0] CMD_PROG     = 8'h80;
    localparam logic [7:0] CMD_PROG_CFM = 8'h10;
    localparam logic [7:0] CMD_READ_ID  = 8'h90;
    localparam logic [7:0] CMD_STATUS   = 8'h70;
    localparam logic [7:0] CMD_RESET    = 8'hFF;

    localparam logic [7:0] ID_BYTES [5] = '{8'h2C, 8'hE5, 8'hFF, 8'h03, 8'h86};

    typedef enum logic [2:0] {ST_IDLE, ST_ADDR, ST_BUSY, ST_DOUT, ST_DIN} state_t;
    typedef enum logic [1:0] {MODE_NONE, MODE_ID, MODE_STATUS, MODE_PAGE} mode_t;

    // Reads past the end of the ID sequence return zero
    function automatic logic [7:0] id_byte(input logic [2:0] idx);
        if (idx < 3'd5)
            return ID_BYTES[idx];
        return 8'h00;
    endfunction

endpackage

// File: rtl/nand_page_ram.sv
// rtl/nand_page_ram.sv - 256x8 page buffer, synchronous write, asynchronous read
module nand_page_ram (
    input  logic       clk,
    input  logic       wr_en,
    input  logic [7:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic [7:0] rd_addr,
    output logic [7:0] rd_data
);

    logic [7:0] mem [256];

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/nand_target.sv
// rtl/nand_target.sv - clk-sampled ONFI NAND target model (ID, status, page read, reset)
// NAND_TARGET_PROG_EN adds page program backed by nand_page_ram.
module nand_target
    import nand_pkg::*;
#(
    parameter int T_R_CYC    = 20,
    parameter int T_PROG_CYC = 40,
    parameter int T_RST_CYC  = 10
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             nand_cle,
    input  logic             nand_ale,
    input  logic             nand_nwe,
    input  logic             nand_nwp,
    input  logic             nand_nce,
    input  logic             nand_nre,
    output logic             nand_rnb,
    inout  wire logic [15:0] nand_data,
    output logic [7:0]       last_cmd
);

    localparam int CW = 16;

    state_t         state, state_n;
    mode_t          mode, mode_n, prev_mode, prev_mode_n;
    logic           nwe_q, nre_q, drive_en, drive_en_n, fail, fail_n;
    logic [7:0]     last_cmd_n, cur_cmd, cur_cmd_n, col0, col0_n, row0, row0_n, ptr, ptr_n;
    logic [2:0]     addr_cnt, addr_cnt_n, addr_need, id_idx, id_idx_n;
    logic [CW-1:0]  busy_cnt, busy_cnt_n;
    logic           we_rise, re_fall, re_rise, is_cmd, is_addr;
    logic [7:0]     din, page_byte, out_byte;

    assign we_rise   = ~nand_nce & nand_nwe & ~nwe_q;
    assign re_fall   = ~nand_nce & ~nand_nre & nre_q;
    assign re_rise   = ~nand_nce & nand_nre & ~nre_q;
    assign din       = nand_data[7:0];
    assign is_cmd    = we_rise & nand_cle & ~nand_ale;
    assign is_addr   = we_rise & nand_ale & ~nand_cle;
    assign addr_need = (cur_cmd == CMD_READ_ID) ? 3'd1 : 3'd5;
    assign nand_rnb  = (state != ST_BUSY);

`ifdef NAND_TARGET_PROG_EN
    logic is_din, ram_we;
    logic unused_bits;
    assign is_din      = we_rise & ~(nand_cle ^ nand_ale);
    assign unused_bits = ^{nand_data[15:8], row0};

    nand_page_ram u_page_ram (
        .clk     (clk),
        .wr_en   (ram_we),
        .wr_addr (ptr),
        .wr_data (din),
        .rd_addr (ptr),
        .rd_data (page_byte)
    );
`else
    localparam int unused_prog_cyc = T_PROG_CYC;
    logic unused_bits;
    assign unused_bits = ^nand_data[15:8];
    assign page_byte   = ptr ^ row0;
`endif

    always_comb begin
        state_n     = state;
        mode_n      = mode;
        prev_mode_n = prev_mode;
        last_cmd_n  = last_cmd;
        cur_cmd_n   = cur_cmd;
        col0_n      = col0;
        row0_n      = row0;
        ptr_n       = ptr;
        addr_cnt_n  = addr_cnt;
        id_idx_n    = id_idx;
        busy_cnt_n  = busy_cnt;
        fail_n      = fail;
`ifdef NAND_TARGET_PROG_EN
        ram_we      = 1'b0;
`endif
        drive_en_n  = drive_en & ~nand_nre & ~nand_nce;
        if (re_fall && mode != MODE_NONE)
            drive_en_n = 1'b1;

        if (re_rise) begin
            if (mode == MODE_PAGE)
                ptr_n = ptr + 8'd1;
            if (mode == MODE_ID && id_idx < 3'd5)
                id_idx_n = id_idx + 3'd1;
        end

        if (state == ST_BUSY) begin
            if (busy_cnt != '0) begin
                busy_cnt_n = busy_cnt - CW'(1);
            end else begin
                state_n = ST_IDLE;
                case (cur_cmd)
                    CMD_READ: begin
                        state_n = ST_DOUT;
                        ptr_n   = col0;
                        // A status poll during busy keeps STATUS; page data becomes the mode to restore
                        if (mode == MODE_STATUS) prev_mode_n = MODE_PAGE;
                        else                     mode_n      = MODE_PAGE;
                    end
                    CMD_RESET: begin
                        mode_n      = MODE_NONE;
                        prev_mode_n = MODE_NONE;
                    end
                    default: if (mode != MODE_STATUS) mode_n = MODE_NONE;
                endcase
            end
        end

        if (is_cmd) begin
            if (din == CMD_RESET) begin
                last_cmd_n  = din;
                cur_cmd_n   = din;
                state_n     = ST_BUSY;
                mode_n      = MODE_NONE;
                prev_mode_n = MODE_NONE;
                addr_cnt_n  = 3'd0;
                busy_cnt_n  = CW'(T_RST_CYC - 1);
                drive_en_n  = 1'b0;
            end else if (din == CMD_STATUS) begin
                last_cmd_n = din;
                if (mode != MODE_STATUS)
                    prev_mode_n = mode;
                mode_n = MODE_STATUS;
            end else if (state != ST_BUSY) begin
                last_cmd_n = din;
                state_n    = ST_IDLE;
                mode_n     = MODE_NONE;
                case (din)
                    CMD_READ: begin
                        cur_cmd_n  = din;
                        state_n    = ST_ADDR;
                        addr_cnt_n = 3'd0;
                        mode_n     = (mode == MODE_STATUS) ? prev_mode : mode;
                    end
                    CMD_READ_CFM: begin
                        if (state == ST_ADDR && cur_cmd == CMD_READ && addr_cnt == 3'd5) begin
                            state_n    = ST_BUSY;
                            busy_cnt_n = CW'(T_R_CYC - 1);
                        end
                    end
                    CMD_READ_ID: begin
                        cur_cmd_n  = din;
                        state_n    = ST_ADDR;
                        addr_cnt_n = 3'd0;
                    end
`ifdef NAND_TARGET_PROG_EN
                    CMD_PROG: begin
                        cur_cmd_n  = din;
                        state_n    = ST_ADDR;
                        addr_cnt_n = 3'd0;
                    end
                    CMD_PROG_CFM: begin
                        if ((state == ST_ADDR || state == ST_DIN) && cur_cmd == CMD_PROG
                            && addr_cnt == 3'd5) begin
                            if (nand_nwp) begin
                                state_n    = ST_BUSY;
                                busy_cnt_n = CW'(T_PROG_CYC - 1);
                                fail_n     = 1'b0;
                            end else begin
                                fail_n = 1'b1;
                            end
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end

        if (is_addr && state == ST_ADDR && addr_cnt < addr_need) begin
            addr_cnt_n = addr_cnt + 3'd1;
            case (addr_cnt)
                3'd0: begin col0_n = din; ptr_n = din; end
                3'd2: row0_n = din;
                default: ;
            endcase
            if (cur_cmd == CMD_READ_ID) begin
                state_n  = ST_DOUT;
                mode_n   = MODE_ID;
                id_idx_n = 3'd0;
            end
        end

`ifdef NAND_TARGET_PROG_EN
        // Write-protect only suppresses the array update; the pointer still walks
        if (is_din && (state == ST_ADDR || state == ST_DIN) && cur_cmd == CMD_PROG
            && addr_cnt == 3'd5) begin
            state_n = ST_DIN;
            ram_we  = nand_nwp;
            ptr_n   = ptr + 8'd1;
        end
`endif
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state     <= ST_IDLE;
            mode      <= MODE_NONE;
            prev_mode <= MODE_NONE;
            nwe_q     <= 1'b1;
            nre_q     <= 1'b1;
            drive_en  <= 1'b0;
            fail      <= 1'b0;
            last_cmd  <= 8'h00;
            cur_cmd   <= 8'h00;
            col0      <= 8'h00;
            row0      <= 8'h00;
            ptr       <= 8'h00;
            addr_cnt  <= 3'd0;
            id_idx    <= 3'd0;
            busy_cnt  <= '0;
        end else begin
            state     <= state_n;
            mode      <= mode_n;
            prev_mode <= prev_mode_n;
            nwe_q     <= nand_nwe;
            nre_q     <= nand_nre;
            drive_en  <= drive_en_n;
            fail      <= fail_n;
            last_cmd  <= last_cmd_n;
            cur_cmd   <= cur_cmd_n;
            col0      <= col0_n;
            row0      <= row0_n;
            ptr       <= ptr_n;
            addr_cnt  <= addr_cnt_n;
            id_idx    <= id_idx_n;
            busy_cnt  <= busy_cnt_n;
        end
    end

    always_comb begin
        case (mode)
            MODE_ID:     out_byte = id_byte(id_idx);
            MODE_STATUS: out_byte = {nand_nwp, nand_rnb, nand_rnb, 4'b0000, fail};
            MODE_PAGE:   out_byte = page_byte;
            default:     out_byte = 8'h00;
        endcase
    end

    assign nand_data = (drive_en & ~nand_nre & ~nand_nce) ? {8'h00, out_byte} : 16'hzzzz;

endmodule

// File: tb/tb_nand_target.sv
// tb/tb_nand_target.sv - directed self-checking bench for nand_target
`timescale 1ns/1ps
module tb_nand_target;

    logic        clk = 1'b0, nreset = 1'b0;
    logic        cle = 1'b0, ale = 1'b0, nwe = 1'b1, nwp = 1'b1, nce = 1'b1, nre = 1'b1;
    logic [15:0] host_d = 16'h0000;
    logic        host_oe = 1'b0;
    wire  [15:0] nand_data;
    wire         rnb;
    wire  [7:0]  last_cmd;
    int          errors = 0, checks = 0;
    int          lows;
    logic [15:0] v;
    logic [7:0]  id_exp [6] = '{8'h2C, 8'hE5, 8'hFF, 8'h03, 8'h86, 8'h00};

    localparam logic [15:0] BUS_Z = 16'hFFFF;

    always #5 clk = ~clk;

    assign nand_data = host_oe ? host_d : 16'hzzzz;

    // Pull-ups make an undriven bus read as FFFF; the target only ever drives 00xx
    for (genvar i = 0; i < 16; i++) begin : g_pu
        pullup (nand_data[i]);
    end

    nand_target dut (
        .clk       (clk),
        .nreset    (nreset),
        .nand_cle  (cle),
        .nand_ale  (ale),
        .nand_nwe  (nwe),
        .nand_nwp  (nwp),
        .nand_nce  (nce),
        .nand_nre  (nre),
        .nand_rnb  (rnb),
        .nand_data (nand_data),
        .last_cmd  (last_cmd)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic c, input logic a, input logic [7:0] b);
        @(negedge clk);
        cle = c; ale = a; host_d = {8'h00, b}; host_oe = 1'b1; nwe = 1'b0;
        tick(2);
        nwe = 1'b1;
        tick(2);
        cle = 1'b0; ale = 1'b0; host_oe = 1'b0;
    endtask

    task automatic cmd(input logic [7:0] b);  wr(1'b1, 1'b0, b); endtask
    task automatic addr(input logic [7:0] b); wr(1'b0, 1'b1, b); endtask
    task automatic dat(input logic [7:0] b);  wr(1'b0, 1'b0, b); endtask

    task automatic addr5(input logic [7:0] c0, input logic [7:0] c1, input logic [7:0] r0);
        addr(c0); addr(c1); addr(r0); addr(8'h00); addr(8'h00);
    endtask

    // Issue a command and count busy-low samples over a fixed window starting at the nWE rise
    task automatic cmd_count(input logic [7:0] b, input int window, output int n);
        @(negedge clk);
        cle = 1'b1; host_d = {8'h00, b}; host_oe = 1'b1; nwe = 1'b0;
        tick(2);
        nwe = 1'b1;
        n = 0;
        for (int i = 0; i < window; i++) begin
            @(negedge clk);
            if (rnb === 1'b0) n++;
        end
        cle = 1'b0; host_oe = 1'b0;
    endtask

    task automatic rd(output logic [15:0] val);
        @(negedge clk);
        nre = 1'b0;
        tick(2);
        val = nand_data;
        nre = 1'b1;
        tick(2);
    endtask

    task automatic wait_ready(input string tag);
        for (int i = 0; i < 200 && rnb !== 1'b1; i++) @(negedge clk);
        check(tag, {15'd0, rnb}, 16'd1);
    endtask

    initial begin
        tick(3);
        check("rst_rnb", {15'd0, rnb}, 16'd1);
        check("rst_last_cmd", {8'h00, last_cmd}, 16'h0000);
        check("rst_bus", nand_data, BUS_Z);
        nreset = 1'b1;
        nce = 1'b0;
        tick(2);

        cmd(8'h90); addr(8'h00);
        for (int i = 0; i < 6; i++) begin
            rd(v);
            check($sformatf("id_byte%0d", i), v, {8'h00, id_exp[i]});
        end
        check("id_last_cmd", {8'h00, last_cmd}, 16'h0090);

        cmd(8'h55);
        check("unknown_last_cmd", {8'h00, last_cmd}, 16'h0055);
        rd(v);
        check("unknown_bus_z", v, BUS_Z);

        cmd(8'h00); addr5(8'hFE, 8'h00, 8'h05);
        cmd_count(8'h30, 40, lows);
        check("read_busy_cycles", 16'(lows), 16'd20);
`ifndef NAND_TARGET_PROG_EN
        rd(v); check("page_fe", v, 16'h00FB);
        rd(v); check("page_ff", v, 16'h00FA);
        rd(v); check("page_wrap_00", v, 16'h0005);
        rd(v); check("page_01", v, 16'h0004);
`endif

        cmd(8'h00); addr5(8'hFE, 8'h00, 8'h05); cmd(8'h30);
        cmd(8'h90);
        check("busy_ignores_cmd", {8'h00, last_cmd}, 16'h0030);
        cmd(8'h70);
        rd(v); check("status_busy", v, 16'h0080);
        wait_ready("status_ready_wait");
        cmd(8'h70);
        rd(v); check("status_ready", v, 16'h00E0);
        cmd(8'h00);
`ifndef NAND_TARGET_PROG_EN
        rd(v); check("restore_page", v, 16'h00FB);
`endif

        cmd(8'h00); addr5(8'h00, 8'h00, 8'h01); cmd(8'h30);
        tick(3);
        cmd_count(8'hFF, 30, lows);
        check("reset_busy_cycles", 16'(lows), 16'd10);
        check("reset_last_cmd", {8'h00, last_cmd}, 16'h00FF);
        rd(v); check("reset_bus_z", v, BUS_Z);

`ifdef NAND_TARGET_PROG_EN
        cmd(8'h80); addr5(8'h0A, 8'h00, 8'h00); dat(8'hAA); dat(8'h55);
        cmd_count(8'h10, 60, lows);
        check("prog_busy_cycles", 16'(lows), 16'd40);
        cmd(8'h00); addr5(8'h0A, 8'h00, 8'h00); cmd(8'h30);
        wait_ready("prog_read_wait");
        rd(v); check("prog_rd0", v, 16'h00AA);
        rd(v); check("prog_rd1", v, 16'h0055);
        nwp = 1'b0;
        cmd(8'h80); addr5(8'h0A, 8'h00, 8'h00); dat(8'h11); dat(8'h22);
        cmd_count(8'h10, 20, lows);
        check("wp_busy_cycles", 16'(lows), 16'd0);
        cmd(8'h70);
        rd(v); check("wp_status", v, 16'h0061);
        cmd(8'h00); addr5(8'h0A, 8'h00, 8'h00); cmd(8'h30);
        wait_ready("wp_read_wait");
        rd(v); check("wp_rd0", v, 16'h00AA);
        rd(v); check("wp_rd1", v, 16'h0055);
        nwp = 1'b1;
`else
        cmd(8'h80);
        check("prog_noop_last_cmd", {8'h00, last_cmd}, 16'h0080);
        rd(v); check("prog_noop_bus_z", v, BUS_Z);
`endif

        cmd(8'h90); addr(8'h00);
        @(negedge clk);
        nre = 1'b0;
        tick(2);
        check("dout_before_reset", nand_data, 16'h002C);
        #2 nreset = 1'b0;
        #1;
        check("nreset_bus_z", nand_data, BUS_Z);
        check("nreset_rnb", {15'd0, rnb}, 16'd1);
        check("nreset_last_cmd", {8'h00, last_cmd}, 16'h0000);
        nre = 1'b1;
        tick(2);
        nreset = 1'b1;
        tick(2);

        cmd(8'h00); addr5(8'h00, 8'h00, 8'h00); cmd(8'h30);
        check("busy_before_nreset", {15'd0, rnb}, 16'd0);
        #2 nreset = 1'b0;
        #1;
        check("nreset_abort_rnb", {15'd0, rnb}, 16'd1);
        tick(1);
        nreset = 1'b1;
        tick(3);
        check("no_residual_busy", {15'd0, rnb}, 16'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1);
    end

endmodule
